// File: rtl/psum_acc_pkg.sv
// Shared types and helpers for the partial-sum accumulation controller.
package psum_acc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        RUN,
        DRAIN
    } state_t;

    typedef enum logic {
        OP_ACC,
        OP_RD
    } op_t;

    function automatic int unsigned lane_lsb(int unsigned lane, int unsigned lane_bw);
        return lane * lane_bw;
    endfunction

endpackage

// File: rtl/psum_acc_ctrl_if.sv
// Requester, readout and SRAM-side signals of the accumulation controller.
interface psum_acc_ctrl_if #(
    parameter int unsigned AW = 11,
    parameter int unsigned BW = 128
);
    logic          init_start;
    logic          init_done;
    logic          acc_valid;
    logic          acc_ready;
    logic          acc_first;
    logic [AW-1:0] acc_addr;
    logic [BW-1:0] acc_data;
    logic          rd_req;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [BW-1:0] rd_data;
    logic          sram_CEN;
    logic          sram_REN;
    logic          sram_WEN;
    logic [AW-1:0] sram_A_rd;
    logic [AW-1:0] sram_A_wr;
    logic [BW-1:0] sram_D;
    logic [BW-1:0] sram_Q;

    modport slave (
        input  init_start, acc_valid, acc_first, acc_addr, acc_data,
               rd_req, rd_addr, sram_Q,
        output init_done, acc_ready, rd_ready, rd_valid, rd_data,
               sram_CEN, sram_REN, sram_WEN, sram_A_rd, sram_A_wr, sram_D
    );

    modport master (
        output init_start, acc_valid, acc_first, acc_addr, acc_data,
               rd_req, rd_addr, sram_Q,
        input  init_done, acc_ready, rd_ready, rd_valid, rd_data,
               sram_CEN, sram_REN, sram_WEN, sram_A_rd, sram_A_wr, sram_D
    );

endinterface

// File: rtl/psum_lane_add.sv
// Lane-wise wraparound adder: no carry crosses a lane boundary.
module psum_lane_add
    import psum_acc_pkg::*;
#(
    parameter int unsigned col     = 8,
    parameter int unsigned psum_bw = 16
) (
    input  logic [col*psum_bw-1:0] a,
    input  logic [col*psum_bw-1:0] b,
    output logic [col*psum_bw-1:0] sum
);

    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < col; i++) begin
            sum[lane_lsb(i, psum_bw) +: psum_bw] =
                a[lane_lsb(i, psum_bw) +: psum_bw] + b[lane_lsb(i, psum_bw) +: psum_bw];
        end
    end

endmodule

// File: rtl/psum_acc_ctrl.sv
// Read-add-write sequencer and acc/readout arbiter for the dual-address
// partial-sum SRAM, with forwarding around the same-address collision.
module psum_acc_ctrl
    import psum_acc_pkg::*;
#(
    parameter int unsigned num     = 2048,
    parameter int unsigned col     = 8,
    parameter int unsigned psum_bw = 16
) (
    input  logic           CLK,
    input  logic           reset,
    psum_acc_ctrl_if.slave bus
);

    localparam int unsigned   AW   = $clog2(num);
    localparam int unsigned   BW   = col * psum_bw;
    localparam logic [AW-1:0] LAST = AW'(num - 1);

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] cnt;
    logic          init_done_r;
    logic          rr_acc;

    logic          s1_valid;
    op_t           s1_op;
    logic          s1_first;
    logic          s1_fwd;
    logic [AW-1:0] s1_addr;
    logic [BW-1:0] s1_data;
    logic [BW-1:0] fwd_data;

    logic          run_open;
    logic          gnt_acc;
    logic          gnt_rd;
    logic          s0_go;
    logic [AW-1:0] s0_addr;
    logic          s0_hit;
    logic [BW-1:0] operand;
    logic [BW-1:0] add_sum;
    logic [BW-1:0] s1_sum;

    // Grants are withheld while init_start is seen in RUN so nothing enters
    // S1 on the way into INIT/DRAIN.
    assign run_open      = (state == RUN) && !bus.init_start;
    assign bus.acc_ready = run_open && (!bus.rd_req || rr_acc);
    assign bus.rd_ready  = run_open && (!bus.acc_valid || !rr_acc);
    assign gnt_acc       = bus.acc_valid && bus.acc_ready;
    assign gnt_rd        = bus.rd_req && bus.rd_ready;
    assign s0_go         = gnt_acc || gnt_rd;
    assign s0_addr       = gnt_acc ? bus.acc_addr : bus.rd_addr;
    assign s0_hit        = s1_valid && (s1_op == OP_ACC) && (s1_addr == s0_addr);

    assign operand       = s1_fwd ? fwd_data : bus.sram_Q;
    assign s1_sum        = s1_first ? s1_data : add_sum;
    assign bus.init_done = init_done_r;

    psum_lane_add #(
        .col     (col),
        .psum_bw (psum_bw)
    ) u_lane_add (
        .a   (operand),
        .b   (s1_data),
        .sum (add_sum)
    );

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (bus.init_start) state_nx = INIT;
            INIT:  if (cnt == LAST) state_nx = RUN;
            RUN:   if (bus.init_start) state_nx = s1_valid ? DRAIN : INIT;
            DRAIN: state_nx = INIT;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.sram_CEN  = 1'b1;
        bus.sram_REN  = 1'b1;
        bus.sram_WEN  = 1'b1;
        bus.sram_A_rd = '0;
        bus.sram_A_wr = '0;
        bus.sram_D    = '0;
        bus.rd_valid  = 1'b0;
        bus.rd_data   = '0;

        if (state == INIT) begin
            bus.sram_CEN  = 1'b0;
            bus.sram_WEN  = 1'b0;
            bus.sram_A_wr = cnt;
        end

        if (s1_valid) begin
            if (s1_op == OP_ACC) begin
                bus.sram_CEN  = 1'b0;
                bus.sram_WEN  = 1'b0;
                bus.sram_A_wr = s1_addr;
                bus.sram_D    = s1_sum;
            end else begin
                bus.rd_valid = 1'b1;
                bus.rd_data  = operand;
            end
        end

        // A read colliding with the S1 write stays off so the write lands;
        // the op picks its operand from fwd_data instead.
        if (s0_go) begin
            bus.sram_CEN  = 1'b0;
            bus.sram_REN  = s0_hit;
            bus.sram_A_rd = s0_addr;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            init_done_r <= 1'b0;
            rr_acc      <= 1'b1;
            s1_valid    <= 1'b0;
            s1_op       <= OP_ACC;
            s1_first    <= 1'b0;
            s1_fwd      <= 1'b0;
            s1_addr     <= '0;
            s1_data     <= '0;
            fwd_data    <= '0;
        end else begin
            cnt         <= (state == INIT && state_nx == INIT) ? cnt + 1'b1 : '0;
            init_done_r <= (state == INIT) && (state_nx == RUN);
            if (bus.acc_valid && bus.rd_req && s0_go) begin
                rr_acc <= ~rr_acc;
            end
            s1_valid <= s0_go;
            s1_op    <= gnt_acc ? OP_ACC : OP_RD;
            s1_first <= gnt_acc && bus.acc_first;
            s1_fwd   <= s0_go && s0_hit;
            s1_addr  <= s0_addr;
            s1_data  <= bus.acc_data;
            fwd_data <= s1_sum;
        end
    end

endmodule
